// File: rtl/fibonacci_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : fibonacci_checker_if
// Brief    : Beat, control and diagnostic signals of the Fibonacci checker.
// Revision : 1.0 - initial release
// ============================================================================
interface fibonacci_checker_if #(
    parameter int W     = 16,
    parameter int IDX_W = 16
);
    logic             clear;
    logic             in_valid0;
    logic             in_valid1;
    logic [W-1:0]     in_num0;
    logic [W-1:0]     in_num1;
    logic             in_ready;
    logic [IDX_W-1:0] ok_count;
    logic             err;
    logic             proto_err;
    logic [IDX_W-1:0] err_index;
    logic [W-1:0]     err_expected;
    logic [W-1:0]     err_actual;

    modport master (
        output clear, in_valid0, in_valid1, in_num0, in_num1,
        input  in_ready, ok_count, err, proto_err, err_index, err_expected, err_actual
    );

    modport slave (
        input  clear, in_valid0, in_valid1, in_num0, in_num1,
        output in_ready, ok_count, err, proto_err, err_index, err_expected, err_actual
    );
endinterface
`default_nettype wire

// File: rtl/fibonacci_checker.sv
`default_nettype none
// ============================================================================
// Module   : fibonacci_checker
// Brief    : Checks a 1- or 2-element-per-cycle Fibonacci stream, counts
//            matches and latches diagnostics for the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module fibonacci_checker #(
    parameter int          W      = 16,
    parameter int          IDX_W  = 16,
    parameter int unsigned START0 = 1,
    parameter int unsigned START1 = 1
) (
    input  logic               clk,
    input  logic               rst,
    fibonacci_checker_if.slave bus
);
    localparam logic [0:0]   S_CHECK  = 1'b0;
    localparam logic [0:0]   S_ERROR  = 1'b1;
    localparam logic [W-1:0] C_START0 = W'(START0);
    localparam logic [W-1:0] C_START1 = W'(START1);

    logic [0:0]       r_state, w_state_nxt;
    logic [W-1:0]     r_exp_a, w_exp_a_nxt;
    logic [W-1:0]     r_exp_b, w_exp_b_nxt;
    logic [IDX_W-1:0] r_elem_idx, w_elem_idx_nxt;
    logic [IDX_W-1:0] r_ok_count, w_ok_count_nxt;
    logic             r_err, w_err_nxt;
    logic             r_proto_err, w_proto_err_nxt;
    logic [IDX_W-1:0] r_err_index, w_err_index_nxt;
    logic [W-1:0]     r_err_expected, w_err_expected_nxt;
    logic [W-1:0]     r_err_actual, w_err_actual_nxt;

    logic             w_accept;
    logic             w_match0;
    logic             w_match1;
    logic [W-1:0]     w_sum;
    logic [W-1:0]     w_sum2;
    logic [1:0]       w_inc;
    logic [IDX_W:0]   w_ok_ext;

    assign bus.in_ready = ~(rst | bus.clear);
    assign w_accept     = bus.in_ready & (bus.in_valid0 | bus.in_valid1);
    assign w_match0     = (bus.in_num0 == r_exp_a);
    assign w_match1     = (bus.in_num1 == r_exp_b);
    // Two-step advance: next pair is (a+b, a+2b).
    assign w_sum        = r_exp_a + r_exp_b;
    assign w_sum2       = w_sum + r_exp_b;

    always_comb begin
        w_state_nxt        = r_state;
        w_exp_a_nxt        = r_exp_a;
        w_exp_b_nxt        = r_exp_b;
        w_elem_idx_nxt     = r_elem_idx;
        w_err_nxt          = r_err;
        w_proto_err_nxt    = r_proto_err;
        w_err_index_nxt    = r_err_index;
        w_err_expected_nxt = r_err_expected;
        w_err_actual_nxt   = r_err_actual;
        w_inc              = 2'd0;

        if (w_accept && (r_state == S_CHECK)) begin
            if (!bus.in_valid0) begin
                w_proto_err_nxt = 1'b1;
            end else begin
                if (bus.in_valid1) begin
                    w_exp_a_nxt    = w_sum;
                    w_exp_b_nxt    = w_sum2;
                    w_elem_idx_nxt = r_elem_idx + IDX_W'(2);
                end else begin
                    w_exp_a_nxt    = r_exp_b;
                    w_exp_b_nxt    = w_sum;
                    w_elem_idx_nxt = r_elem_idx + IDX_W'(1);
                end

                if (!w_match0) begin
                    w_state_nxt        = S_ERROR;
                    w_err_nxt          = 1'b1;
                    w_err_index_nxt    = r_elem_idx;
                    w_err_expected_nxt = r_exp_a;
                    w_err_actual_nxt   = bus.in_num0;
                end else if (bus.in_valid1 && !w_match1) begin
                    w_state_nxt        = S_ERROR;
                    w_err_nxt          = 1'b1;
                    w_err_index_nxt    = r_elem_idx + IDX_W'(1);
                    w_err_expected_nxt = r_exp_b;
                    w_err_actual_nxt   = bus.in_num1;
                    w_inc              = 2'd1;
                end else begin
                    w_inc = bus.in_valid1 ? 2'd2 : 2'd1;
                end
            end
        end

        w_ok_ext       = {1'b0, r_ok_count} + (IDX_W+1)'(w_inc);
        w_ok_count_nxt = w_ok_ext[IDX_W] ? {IDX_W{1'b1}} : w_ok_ext[IDX_W-1:0];

        // Restart wins over whatever beat arrived alongside it.
        if (bus.clear) begin
            w_state_nxt        = S_CHECK;
            w_exp_a_nxt        = C_START0;
            w_exp_b_nxt        = C_START1;
            w_elem_idx_nxt     = '0;
            w_ok_count_nxt     = '0;
            w_err_nxt          = 1'b0;
            w_proto_err_nxt    = 1'b0;
            w_err_index_nxt    = '0;
            w_err_expected_nxt = '0;
            w_err_actual_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_CHECK;
            r_exp_a        <= C_START0;
            r_exp_b        <= C_START1;
            r_elem_idx     <= '0;
            r_ok_count     <= '0;
            r_err          <= 1'b0;
            r_proto_err    <= 1'b0;
            r_err_index    <= '0;
            r_err_expected <= '0;
            r_err_actual   <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_exp_a        <= w_exp_a_nxt;
            r_exp_b        <= w_exp_b_nxt;
            r_elem_idx     <= w_elem_idx_nxt;
            r_ok_count     <= w_ok_count_nxt;
            r_err          <= w_err_nxt;
            r_proto_err    <= w_proto_err_nxt;
            r_err_index    <= w_err_index_nxt;
            r_err_expected <= w_err_expected_nxt;
            r_err_actual   <= w_err_actual_nxt;
        end
    end

    assign bus.ok_count     = r_ok_count;
    assign bus.err          = r_err;
    assign bus.proto_err    = r_proto_err;
    assign bus.err_index    = r_err_index;
    assign bus.err_expected = r_err_expected;
    assign bus.err_actual   = r_err_actual;
endmodule
`default_nettype wire

// File: tb/tb_fibonacci_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fibonacci_checker
// Brief    : Scoreboard bench for fibonacci_checker against an index-based
//            Fibonacci reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fibonacci_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fibonacci_checker_if #(.W(16), .IDX_W(16)) bus();

    fibonacci_checker #(.W(16), .IDX_W(16), .START0(1), .START1(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ok;
        logic        err;
        logic        perr;
        logic [15:0] eidx;
        logic [15:0] eexp;
        logic [15:0] eact;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: position in the sequence plus sticky diagnostics.
    int          m_idx;
    int          m_ok;
    logic        m_err, m_perr;
    logic [15:0] m_eidx, m_eexp, m_eact;

    function automatic logic [15:0] fib_at(int n);
        int a = 1;
        int b = 1;
        int t;
        if (n == 0) return 16'(a);
        for (int i = 1; i < n; i++) begin
            t = (a + b) & 65535;
            a = b;
            b = t;
        end
        return 16'(b);
    endfunction

    task automatic cmp(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_ok = 0; m_err = 0; m_perr = 0;
        m_eidx = 0; m_eexp = 0; m_eact = 0;
    endtask

    task automatic model_latch(int idx, logic [15:0] expv, logic [15:0] actv);
        m_err = 1; m_eidx = 16'(idx); m_eexp = expv; m_eact = actv;
    endtask

    task automatic model_step(logic r, logic c, logic v0, logic v1,
                              logic [15:0] n0, logic [15:0] n1);
        if (r || c) begin
            model_reset();
        end else if (!m_err) begin
            if (v1 && !v0) begin
                m_perr = 1;
            end else if (v0) begin
                if (n0 != fib_at(m_idx)) begin
                    model_latch(m_idx, fib_at(m_idx), n0);
                end else begin
                    m_ok = (m_ok < 65535) ? m_ok + 1 : m_ok;
                    if (v1) begin
                        if (n1 != fib_at(m_idx + 1)) model_latch(m_idx + 1, fib_at(m_idx + 1), n1);
                        else m_ok = (m_ok < 65535) ? m_ok + 1 : m_ok;
                    end
                end
                m_idx += v1 ? 2 : 1;
            end
        end
    endtask

    task automatic beat(logic r, logic c, logic v0, logic v1,
                        logic [15:0] n0, logic [15:0] n1);
        exp_t e;
        @(negedge clk);
        rst = r; bus.clear = c;
        bus.in_valid0 = v0; bus.in_valid1 = v1;
        bus.in_num0 = n0; bus.in_num1 = n1;
        model_step(r, c, v0, v1, n0, n1);
        e.ok = 16'(m_ok); e.err = m_err; e.perr = m_perr;
        e.eidx = m_eidx; e.eexp = m_eexp; e.eact = m_eact;
        q.push_back(e);
        #1;
        cmp("in_ready", int'(bus.in_ready), int'(!(r || c)));
    endtask

    task automatic idle();         beat(0, 0, 0, 0, 16'd0, 16'd0); endtask
    task automatic clr();          beat(0, 1, 0, 0, 16'd0, 16'd0); endtask
    task automatic send1();        beat(0, 0, 1, 0, fib_at(m_idx), 16'd0); endtask
    task automatic send2();        beat(0, 0, 1, 1, fib_at(m_idx), fib_at(m_idx + 1)); endtask
    task automatic pair(logic [15:0] a, logic [15:0] b); beat(0, 0, 1, 1, a, b); endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: outputs are registered, so each edge retires one queued beat.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                cmp("ok_count",     int'(bus.ok_count),     int'(e.ok));
                cmp("err",          int'(bus.err),          int'(e.err));
                cmp("proto_err",    int'(bus.proto_err),    int'(e.perr));
                cmp("err_index",    int'(bus.err_index),    int'(e.eidx));
                cmp("err_expected", int'(bus.err_expected), int'(e.eexp));
                cmp("err_actual",   int'(bus.err_actual),   int'(e.eact));
            end
        end
    end

    initial begin
        int r;
        logic [15:0] n0, n1;
        bus.clear = 0; bus.in_valid0 = 0; bus.in_valid1 = 0;
        bus.in_num0 = 0; bus.in_num1 = 0;
        model_reset();

        for (int i = 0; i < 3; i++) beat(1, 0, 1, 1, 16'd7, 16'd9);
        settle();
        cmp("reset ok_count", int'(bus.ok_count), 0);
        cmp("reset err", int'(bus.err), 0);

        // Single rate, ten elements.
        for (int i = 0; i < 10; i++) send1();
        settle();
        cmp("single ok_count", int'(bus.ok_count), 10);
        cmp("single err", int'(bus.err), 0);

        // Double rate, five pairs.
        clr();
        for (int i = 0; i < 5; i++) send2();
        settle();
        cmp("double ok_count", int'(bus.ok_count), 10);

        // Lane1 mismatch, then frozen outputs.
        clr();
        pair(16'd1, 16'd1); pair(16'd2, 16'd3); pair(16'd5, 16'd9);
        pair(16'd13, 16'd21); beat(0, 0, 1, 0, 16'd99, 16'd0); beat(0, 0, 0, 1, 16'd0, 16'd0);
        settle();
        cmp("inject err_index", int'(bus.err_index), 5);
        cmp("inject err_expected", int'(bus.err_expected), 8);
        cmp("inject err_actual", int'(bus.err_actual), 9);
        cmp("inject ok_count", int'(bus.ok_count), 5);
        cmp("inject proto frozen", int'(bus.proto_err), 0);

        // Lane0 mismatch wins over lane1 mismatch.
        clr();
        pair(16'd1, 16'd1); pair(16'd4, 16'd4);
        settle();
        cmp("lane0 wins err_index", int'(bus.err_index), 2);
        cmp("lane0 wins err_actual", int'(bus.err_actual), 4);

        // Wrap past 2^16: element 24 is 9489.
        clr();
        for (int i = 0; i < 24; i++) send1();
        beat(0, 0, 1, 0, 16'd9489, 16'd0);
        settle();
        cmp("wrap ok_count", int'(bus.ok_count), 25);
        cmp("wrap err", int'(bus.err), 0);

        // Protocol violation then a good beat.
        clr();
        beat(0, 0, 0, 1, 16'd1, 16'd1);
        pair(16'd1, 16'd1);
        settle();
        cmp("proto proto_err", int'(bus.proto_err), 1);
        cmp("proto ok_count", int'(bus.ok_count), 2);

        // Clear mid-run, with a beat presented alongside clear.
        clr();
        for (int i = 0; i < 6; i++) send1();
        beat(0, 1, 1, 1, 16'd8, 16'd13);
        pair(16'd1, 16'd1);
        settle();
        cmp("clear ok_count", int'(bus.ok_count), 2);
        cmp("clear err", int'(bus.err), 0);

        // Randomized traffic with occasional corruption, clears and bad beats.
        clr();
        for (int i = 0; i < 600; i++) begin
            r  = int'($urandom_range(0, 99));
            n0 = fib_at(m_idx);
            n1 = fib_at(m_idx + 1);
            if ($urandom_range(0, 99) < 3) n0 = n0 ^ 16'($urandom_range(1, 65535));
            if ($urandom_range(0, 99) < 3) n1 = n1 ^ 16'($urandom_range(1, 65535));
            if (r < 4)       beat(0, 1, r[0], r[1], n0, n1);
            else if (r < 8)  beat(0, 0, 0, 1, 16'($urandom), 16'($urandom));
            else if (r < 20) beat(0, 0, 0, 0, 16'($urandom), 16'($urandom));
            else if (r < 55) beat(0, 0, 1, 0, n0, 16'($urandom));
            else             beat(0, 0, 1, 1, n0, n1);
        end
        idle();
        idle();
        settle();
        cmp("queue drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
`default_nettype wire
